rf_commit_controller: RTL
=========================

// Module: rf_commit_controller
// PURPOSE
//  Commit sequencer between RoB head and RegisterFile write/flush port. Accepts retired entries
//  by valid/ready, buffers them in a small FIFO, issues at most one RF commit per cycle, and on a
//  mispredicted branch pulses the RF pre_judge-low flush plus a global flush with redirect PC.
// PARAMETERS
//  RoB_WIDTH      8         RoB index width
//  EX_REG_WIDTH   6         extended reg id width; NON_REG = 6'b100000 means no destination
//  FIFO_DEPTH     4         commit buffer entries, power of two, >=2
//  RECOVER_CYCLES 2         cycles input stays blocked after a flush pulse (>=1)
// PORTS
//  Sys_clk          in  1            clock, rising edge
//  Sys_rst          in  1            asynchronous, active-high reset
//  Sys_rdy          in  1            global enable; 0 = stall
//  RoBCC_valid      in  1            RoB offers a retiring entry
//  RoBCC_ready      out 1            entry accepted on edge where valid&ready
//  RoBCC_RoB_index  in  RoB_WIDTH    RoB index of entry
//  RoBCC_rd         in  EX_REG_WIDTH destination, NON_REG if none
//  RoBCC_value      in  32           result value
//  RoBCC_is_branch  in  1            entry is a branch
//  RoBCC_mispredict in  1            branch outcome mispredicted (valid only with is_branch)
//  RoBCC_target_pc  in  32           correct PC for mispredict
//  CCRF_en          out 1            one-cycle commit pulse to RF
//  CCRF_RoB_index   out RoB_WIDTH    committed RoB index
//  CCRF_rd          out EX_REG_WIDTH committed rd (NON_REG for branches)
//  CCRF_value       out 32           committed value
//  CCRF_pre_judge   out 1            0 for exactly one cycle = clear RF dependencies
//  CC_flush         out 1            one-cycle global flush pulse
//  CC_flush_pc      out 32           redirect PC, valid with CC_flush
//  CC_commit_cnt    out 32           retired-entry count, wraps modulo 2^32
// BEHAVIOUR
//  - Reset (async): FIFO empty, state RUN, CCRF_en=0, CCRF_pre_judge=1, CC_flush=0,
//    CC_flush_pc=0, CCRF_RoB_index/rd/value=0, CC_commit_cnt=0. Mid-operation reset drops all entries.
//  - RoBCC_ready = Sys_rdy && state==RUN && count<FIFO_DEPTH (no pass-through when full).
//  - All CC*/CCRF* outputs registered. Pop at edge N+1 after push edge N: min latency 2 edges.
//  - Pop (state RUN, FIFO non-empty, Sys_rdy): head -> CCRF_* with CCRF_en=1, CC_commit_cnt+1.
//    Non-branch: rd passed as-is (NON_REG allowed). Branch: CCRF_rd forced NON_REG.
//  - Mispredicted branch pop: CCRF_en=1, CCRF_pre_judge=0, CC_flush=1, CC_flush_pc=target_pc;
//    FIFO cleared same edge, including any entry pushed that edge; state -> FLUSH.
//  - States: RUN -> FLUSH (mispredict pop) -> RECOVER (next edge; pulses return to idle) ->
//    RUN after RECOVER_CYCLES edges (down-counter). Input blocked in FLUSH and RECOVER.
//  - Pulses: CCRF_en, CC_flush return to 0 and CCRF_pre_judge to 1 on every edge not issuing one.
//  - Sys_rdy=0: FIFO, state, counters hold; pulse outputs return to idle; ready=0.
//  - Simultaneous push+pop in RUN: both occur, count unchanged; pointers wrap modulo FIFO_DEPTH.
// CONFIGURATION
//  RF_COMMIT_PERF_EN defined: adds outputs CC_branch_cnt[31:0], CC_mispredict_cnt[31:0],
//    incremented on branch pop / mispredict pop, reset 0, wrap modulo 2^32, hold on Sys_rdy=0.
//  Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared package: NON_REG, RoB_WIDTH, EX_REG_WIDTH, state encoding (RUN/FLUSH/RECOVER),
//    commit-entry typedef {rob_index, rd, value, is_branch, mispredict, target_pc}.
//  One sub-module: commit_fifo (sync FIFO, push/pop/clear, count, full/empty).
// TESTING
//  1 Reset mid-stream with 3 buffered entries -> FIFO empty, ready=1, CCRF_en=0, pre_judge=1, cnt=0.
//  2 Push rd=5,val=0x1234,idx=7 -> after 2 edges CCRF_en=1 rd=5 val=0x1234 idx=7 for one cycle, cnt=1.
//  3 Hold valid with pops blocked (Sys_rdy=0 after 4 pushes) -> ready=0 at 4; outputs hold idle;
//    on Sys_rdy=1 entries drain in order one per cycle.
//  4 Correct branch rd=3 -> CCRF_rd=NON_REG, pre_judge=1, no flush.
//  5 Mispredict target 0x80 with 2 younger entries queued -> one cycle pre_judge=0, CC_flush=1,
//    flush_pc=0x80; younger entries never committed; ready=0 for 1+RECOVER_CYCLES edges, then 1.
//  6 With RF_COMMIT_PERF_EN: 3 branches, 1 mispredict -> branch_cnt=3, mispredict_cnt=1.

Source files
------------

// File: rtl/rf_commit_controller_pkg.sv
// Shared types and constants for the RF commit controller and its commit buffer.
package rf_commit_controller_pkg;

  localparam int unsigned RoB_WIDTH    = 8;
  localparam int unsigned EX_REG_WIDTH = 6;

  // Extended register id whose MSB alone is set marks "no destination".
  localparam logic [EX_REG_WIDTH-1:0] NON_REG = {1'b1, {(EX_REG_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    StRun,
    StFlush,
    StRecover
  } cc_state_e;

  typedef struct packed {
    logic [RoB_WIDTH-1:0]    rob_index;
    logic [EX_REG_WIDTH-1:0] rd;
    logic [31:0]             value;
    logic                    is_branch;
    logic                    mispredict;
    logic [31:0]             target_pc;
  } commit_entry_t;

endpackage

// File: rtl/rf_commit_controller_commit_fifo.sv
// Synchronous commit buffer with push, pop and a clear that overrides a same-edge push.
module rf_commit_controller_commit_fifo
  import rf_commit_controller_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  logic          Sys_clk,
  input  logic          Sys_rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  commit_entry_t push_entry,
  output commit_entry_t head_entry,
  output logic          full,
  output logic          empty
);

  commit_entry_t   mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;

  assign head_entry = mem_q[rd_ptr_q];
  assign full       = (count_q == (PtrW+1)'(Depth));
  assign empty      = (count_q == '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Depth is a power of two, so pointers wrap by natural overflow.
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + (PtrW+1)'(1);
        2'b01:   count_d = count_q - (PtrW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge Sys_clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: rtl/rf_commit_controller.sv
// Commit sequencer between RoB head and RF: one commit per cycle, flush on mispredict.
// Defining RF_COMMIT_PERF_EN adds the CC_branch_cnt / CC_mispredict_cnt outputs.
module rf_commit_controller
  import rf_commit_controller_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned RECOVER_CYCLES = 2
) (
  input  logic                    Sys_clk,
  input  logic                    Sys_rst,
  input  logic                    Sys_rdy,
  input  logic                    RoBCC_valid,
  output logic                    RoBCC_ready,
  input  logic [RoB_WIDTH-1:0]    RoBCC_RoB_index,
  input  logic [EX_REG_WIDTH-1:0] RoBCC_rd,
  input  logic [31:0]             RoBCC_value,
  input  logic                    RoBCC_is_branch,
  input  logic                    RoBCC_mispredict,
  input  logic [31:0]             RoBCC_target_pc,
  output logic                    CCRF_en,
  output logic [RoB_WIDTH-1:0]    CCRF_RoB_index,
  output logic [EX_REG_WIDTH-1:0] CCRF_rd,
  output logic [31:0]             CCRF_value,
  output logic                    CCRF_pre_judge,
  output logic                    CC_flush,
  output logic [31:0]             CC_flush_pc,
  output logic [31:0]             CC_commit_cnt
`ifdef RF_COMMIT_PERF_EN
  ,
  output logic [31:0]             CC_branch_cnt,
  output logic [31:0]             CC_mispredict_cnt
`endif
);

  localparam int unsigned RecW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

  cc_state_e     state_q, state_d;
  logic [RecW-1:0] rec_cnt_q, rec_cnt_d;

  commit_entry_t in_entry, head;
  logic          fifo_full, fifo_empty;
  logic          run, push, pop, mispredict_pop;

  assign in_entry = '{
    rob_index:  RoBCC_RoB_index,
    rd:         RoBCC_rd,
    value:      RoBCC_value,
    is_branch:  RoBCC_is_branch,
    mispredict: RoBCC_mispredict,
    target_pc:  RoBCC_target_pc
  };

  assign run            = Sys_rdy && (state_q == StRun);
  assign RoBCC_ready    = run && !fifo_full;
  assign push           = RoBCC_valid && RoBCC_ready;
  assign pop            = run && !fifo_empty;
  // Mispredict is only meaningful on a branch entry.
  assign mispredict_pop = pop && head.is_branch && head.mispredict;

  rf_commit_controller_commit_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_commit_fifo (
    .Sys_clk    (Sys_clk),
    .Sys_rst    (Sys_rst),
    .push       (push),
    .pop        (pop),
    .clear      (mispredict_pop),
    .push_entry (in_entry),
    .head_entry (head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    rec_cnt_d = rec_cnt_q;
    if (Sys_rdy) begin
      unique case (state_q)
        StRun: begin
          if (mispredict_pop) state_d = StFlush;
        end
        StFlush: begin
          state_d   = StRecover;
          rec_cnt_d = RecW'(RECOVER_CYCLES - 1);
        end
        StRecover: begin
          if (rec_cnt_q == '0) state_d = StRun;
          else                 rec_cnt_d = rec_cnt_q - RecW'(1);
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      state_q   <= StRun;
      rec_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rec_cnt_q <= rec_cnt_d;
    end
  end

  // Pulse outputs fall back to idle on every edge without a pop; payload holds.
  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      CCRF_en        <= 1'b0;
      CCRF_RoB_index <= '0;
      CCRF_rd        <= '0;
      CCRF_value     <= '0;
      CCRF_pre_judge <= 1'b1;
      CC_flush       <= 1'b0;
      CC_flush_pc    <= '0;
      CC_commit_cnt  <= '0;
    end else begin
      CCRF_en        <= pop;
      CCRF_pre_judge <= !mispredict_pop;
      CC_flush       <= mispredict_pop;
      if (pop) begin
        CCRF_RoB_index <= head.rob_index;
        CCRF_rd        <= head.is_branch ? NON_REG : head.rd;
        CCRF_value     <= head.value;
        CC_commit_cnt  <= CC_commit_cnt + 32'd1;
      end
      if (mispredict_pop) CC_flush_pc <= head.target_pc;
    end
  end

`ifdef RF_COMMIT_PERF_EN
  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      CC_branch_cnt     <= '0;
      CC_mispredict_cnt <= '0;
    end else begin
      if (pop && head.is_branch) CC_branch_cnt     <= CC_branch_cnt + 32'd1;
      if (mispredict_pop)        CC_mispredict_cnt <= CC_mispredict_cnt + 32'd1;
    end
  end
`endif

endmodule
